// File: rtl/clk_freq_monitor.sv
// Counts rising edges of async MON_IN over GATE_CYCLES BUS_CLK cycles and range-checks the count.
// Lock tracking (synchronizer, loss counter, FREQ_OK gating) is built only with CLK_FREQ_MONITOR_LOCK_EN defined.
module clk_freq_monitor #(
  parameter int unsigned GATE_CYCLES = 48000,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned MIN_COUNT   = 11900,
  parameter int unsigned MAX_COUNT   = 12100
) (
  input  logic                   BUS_CLK,
  input  logic                   BUS_RST,
  input  logic                   MON_IN,
  input  logic                   DCM_LOCKED,
  input  logic                   START,
  input  logic                   CONT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [COUNT_WIDTH-1:0] COUNT,
  output logic                   FREQ_OK,
  output logic                   LOCKED,
  output logic [7:0]             LOCK_LOSS_CNT
);

  localparam int GATE_W = $clog2(GATE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GATE, DONE_ST} state_t;

  state_t                 state, state_nxt;
  logic                   mon_s1, mon_s2, mon_s3;
  logic                   mon_edge, loss_evt;
  logic                   start_win, gate_last, in_range;
  logic [GATE_W-1:0]      gate_cnt;
  logic [COUNT_WIDTH-1:0] edge_cnt, edge_cnt_nxt;
  logic                   lock_lost, lock_lost_nxt;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      mon_s1 <= 1'b0;
      mon_s2 <= 1'b0;
      mon_s3 <= 1'b0;
    end else begin
      mon_s1 <= MON_IN;
      mon_s2 <= mon_s1;
      mon_s3 <= mon_s2;
    end
  end

  assign mon_edge = mon_s2 & ~mon_s3;

`ifdef CLK_FREQ_MONITOR_LOCK_EN
  logic lock_s1, lock_s2, lock_s3;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      lock_s1       <= 1'b0;
      lock_s2       <= 1'b0;
      lock_s3       <= 1'b0;
      LOCK_LOSS_CNT <= 8'd0;
    end else begin
      lock_s1 <= DCM_LOCKED;
      lock_s2 <= lock_s1;
      lock_s3 <= lock_s2;
      if (loss_evt && LOCK_LOSS_CNT != 8'hFF)
        LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
    end
  end

  assign loss_evt = ~lock_s2 & lock_s3;
  assign LOCKED   = lock_s2;
`else
  logic lock_unused;
  assign lock_unused   = DCM_LOCKED;
  assign loss_evt      = 1'b0;
  assign LOCKED        = 1'b1;
  assign LOCK_LOSS_CNT = 8'd0;
`endif

  assign gate_last = (state == GATE) && (gate_cnt == GATE_W'(GATE_CYCLES));
  assign BUSY      = (state == GATE);
  assign DONE      = (state == DONE_ST);

  always_comb begin
    state_nxt = state;
    start_win = 1'b0;
    case (state)
      IDLE: begin
        if (START || CONT) begin
          state_nxt = GATE;
          start_win = 1'b1;
        end
      end
      GATE: begin
        if (gate_last) state_nxt = DONE_ST;
      end
      DONE_ST: begin
        if (CONT) begin
          state_nxt = GATE;
          start_win = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result is taken from the next-value so an edge or lock loss on the last gate cycle still counts.
  always_comb begin
    edge_cnt_nxt  = edge_cnt;
    lock_lost_nxt = lock_lost;
    if (state == GATE) begin
      if (mon_edge && edge_cnt != '1) edge_cnt_nxt = edge_cnt + COUNT_WIDTH'(1);
      if (loss_evt) lock_lost_nxt = 1'b1;
    end
  end

  assign in_range = (32'(edge_cnt_nxt) >= MIN_COUNT) && (32'(edge_cnt_nxt) <= MAX_COUNT);

  // gate_cnt is loaded with 1 on entry so it holds the index of the current gate cycle.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state     <= IDLE;
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      lock_lost <= 1'b0;
      COUNT     <= '0;
      FREQ_OK   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_win) begin
        gate_cnt  <= GATE_W'(1);
        edge_cnt  <= '0;
        lock_lost <= 1'b0;
      end else begin
        if (state == GATE && !gate_last) gate_cnt <= gate_cnt + GATE_W'(1);
        edge_cnt  <= edge_cnt_nxt;
        lock_lost <= lock_lost_nxt;
      end
      if (gate_last) begin
        COUNT   <= edge_cnt_nxt;
        FREQ_OK <= in_range & ~lock_lost_nxt;
      end
    end
  end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Bench for clk_freq_monitor: MON_IN/DCM_LOCKED pin history is recorded and expected results are derived from it.
module tb_clk_freq_monitor;

  localparam int G    = 1000;
  localparam int MINC = 240;
  localparam int MAXC = 260;
  localparam int GS   = 100;
  localparam int MINS = 10;
  localparam int MAXS = 20;
`ifdef CLK_FREQ_MONITOR_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, mon_in, dcm, start, cont, start_s;
  logic        busy, done, freq_ok, locked;
  logic [15:0] count;
  logic [7:0]  loss_cnt;
  logic        busy_s, done_s, freq_ok_s, locked_s;
  logic [3:0]  count_s;
  logic [7:0]  loss_cnt_s;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int period = 4;
  int phase = 0;
  int exp_loss = 0;
  logic mh [0:32767];
  logic lh [0:32767];

  clk_freq_monitor #(.GATE_CYCLES(G), .COUNT_WIDTH(16), .MIN_COUNT(MINC), .MAX_COUNT(MAXC)) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .MON_IN(mon_in), .DCM_LOCKED(dcm), .START(start), .CONT(cont),
    .BUSY(busy), .DONE(done), .COUNT(count), .FREQ_OK(freq_ok), .LOCKED(locked), .LOCK_LOSS_CNT(loss_cnt)
  );

  clk_freq_monitor #(.GATE_CYCLES(GS), .COUNT_WIDTH(4), .MIN_COUNT(MINS), .MAX_COUNT(MAXS)) dut_sat (
    .BUS_CLK(clk), .BUS_RST(rst), .MON_IN(mon_in), .DCM_LOCKED(dcm), .START(start_s), .CONT(1'b0),
    .BUSY(busy_s), .DONE(done_s), .COUNT(count_s), .FREQ_OK(freq_ok_s), .LOCKED(locked_s),
    .LOCK_LOSS_CNT(loss_cnt_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitored clock: square wave with an integer period in BUS_CLK cycles.
  always @(posedge clk) begin
    #1;
    mon_in = ((cyc + phase) % period) < (period / 2);
  end

  always @(negedge clk) begin
    if (cyc < 32768) begin
      mh[cyc] = mon_in;
      lh[cyc] = dcm;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A pin rise in cycle c-1 -> c is seen by the edge detector in cycle c+2.
  function automatic int exp_count(input int t, input int g, input int maxv);
    int n = 0;
    for (int d = t + 1; d <= t + g; d++)
      if (mh[d-2] === 1'b1 && mh[d-3] === 1'b0) n++;
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic bit lost_in(input int t, input int g);
    for (int d = t + 1; d <= t + g; d++)
      if (lh[d-3] === 1'b1 && lh[d-2] === 1'b0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_ok(input int n, input int lo, input int hi, input bit lost);
    return (n >= lo) && (n <= hi) && !(lost && LOCK_EN);
  endfunction

  // Starts a window at the current cycle and checks nwin consecutive results.
  task automatic run_win(input int nwin, input bit poke, input int drop_at);
    int t, dc, gap, ec;
    t = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < nwin; k++) begin
      dc = -1;
      gap = 0;
      for (int c = 0; c < G + 10 && dc < 0; c++) begin
        start = poke && (cyc == t + G / 2);
        if (k == nwin - 1 && cyc == t + G / 2) cont = 1'b0;
        if (k == 0 && drop_at > 0 && cyc == t + drop_at) begin
          dcm = 1'b0;
          if (LOCK_EN) exp_loss++;
        end
        if (k == 0 && drop_at > 0 && cyc == t + drop_at + 10) dcm = 1'b1;
        if (done === 1'b1) dc = cyc;
        else begin
          if (busy !== 1'b1) gap++;
          tick();
        end
      end
      ec = exp_count(t, G, 65535);
      chk("done_cycle", dc, t + G + 1);
      chk("busy_in_window", gap, 0);
      chk("busy_at_done", 32'(busy), 0);
      chk("count", 32'(count), ec);
      chk("freq_ok", 32'(freq_ok), 32'(exp_ok(ec, MINC, MAXC, lost_in(t, G))));
      start = poke;
      tick();
      start = 1'b0;
      t = dc;
    end
    gap = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy !== 1'b0 || done !== 1'b0) gap++;
      tick();
    end
    chk("no_extra_window", gap, 0);
  endtask

  initial begin
    int t, dc, gap;
    rst = 1'b1; start = 1'b0; start_s = 1'b0; cont = 1'b0; dcm = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_freq_ok", 32'(freq_ok), 0);
    chk("rst_locked", 32'(locked), LOCK_EN ? 0 : 1);
    chk("rst_loss_cnt", 32'(loss_cnt), 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("locked_up", 32'(locked), 1);

    period = 4; phase = 1;
    repeat (4) tick();
    run_win(1, 1'b0, 0);
    chk("nominal_loss_cnt", 32'(loss_cnt), 0);

    period = 8;
    repeat (4) tick();
    run_win(1, 1'b0, 0);

    period = 4;
    repeat (4) tick();
    run_win(1, 1'b0, 500);
    chk("lock_loss_cnt", 32'(loss_cnt), exp_loss);

    cont = 1'b1;
    run_win(3, 1'b1, 0);

    t = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < t + 500) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_loss = 0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_freq_ok", 32'(freq_ok), 0);
    chk("midrst_loss_cnt", 32'(loss_cnt), 0);
    gap = 0;
    for (int c = 0; c < 6; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) gap++;
      tick();
    end
    chk("midrst_quiet", gap, 0);
    run_win(1, 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      period = $urandom_range(4, 12);
      phase  = $urandom_range(0, 11);
      repeat (4) tick();
      run_win(1, 1'b0, ($urandom_range(0, 1) == 1) ? $urandom_range(100, 900) : 0);
      chk("rand_loss_cnt", 32'(loss_cnt), exp_loss);
    end

    period = 4;
    repeat (4) tick();
    t = cyc;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    dc = -1;
    gap = 0;
    for (int c = 0; c < GS + 10 && dc < 0; c++) begin
      if (done_s === 1'b1) dc = cyc;
      else begin
        if (busy_s !== 1'b1) gap++;
        tick();
      end
    end
    chk("sat_done_cycle", dc, t + GS + 1);
    chk("sat_busy", gap, 0);
    chk("sat_count", 32'(count_s), exp_count(t, GS, 15));
    chk("sat_freq_ok", 32'(freq_ok_s), 32'(exp_ok(exp_count(t, GS, 15), MINS, MAXS, lost_in(t, GS))));
    chk("sat_locked", 32'(locked_s), 1);
    chk("sat_loss_cnt", 32'(loss_cnt_s), exp_loss);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
